// File: rtl/udp_pkt_ser.sv
// UDP byte serializer: optional 8-byte UDP header, then payload words MSB-first.
// Define UDP_PKT_SER_HDR_EN to emit the header; undefined gives payload-only packets.
module udp_pkt_ser #(
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DST_PORT = 16'd1234
) (
  input  logic        eth_tx_clk,
  input  logic        rst,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  output logic        tx_req,
  input  logic [31:0] tx_data,
  output logic        tx_done,
  output logic        tx_busy,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof
);

`ifdef UDP_PKT_SER_HDR_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;

`ifdef UDP_PKT_SER_HDR_EN
  logic [2:0]  hidx_q, hidx_d;
  logic [63:0] hdr_w;

  assign hdr_w = {SRC_PORT, DST_PORT, len_q + 16'd8, 16'h0000};
`else
  logic        wait_q, wait_d;
`endif

  assign tx_req    = tx_req_q;
  assign tx_done   = (state_q == DONE);
  assign tx_busy   = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    lane_d      = lane_q;
    word_d      = word_q;
    tx_req_d    = 1'b0;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
`ifdef UDP_PKT_SER_HDR_EN
    hidx_d      = hidx_q;
`else
    wait_d      = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start_en) begin
          len_d  = tx_byte_num;
          rem_d  = tx_byte_num;
          lane_d = 2'd0;
`ifdef UDP_PKT_SER_HDR_EN
          state_d     = HDR;
          hidx_d      = 3'd1;
          out_valid_d = 1'b1;
          out_sof_d   = 1'b1;
          out_data_d  = hdr_w[63:56];
`else
          if (tx_byte_num == 16'd0) begin
            state_d = DONE;
          end else begin
            // word arrives two cycles later, so skip one cycle first
            state_d  = PAYLOAD;
            tx_req_d = 1'b1;
            wait_d   = 1'b1;
          end
`endif
        end
      end
`ifdef UDP_PKT_SER_HDR_EN
      HDR: begin
        out_valid_d = 1'b1;
        out_data_d  = hdr_w[{~hidx_q, 3'b111} -: 8];
        tx_req_d    = (hidx_q == 3'd6) && (len_q != 16'd0);
        if (hidx_q == 3'd7) begin
          out_eof_d = (len_q == 16'd0);
          state_d   = PAYLOAD;
        end else begin
          hidx_d = hidx_q + 3'd1;
        end
      end
`endif
      PAYLOAD: begin
        if (rem_q == 16'd0) begin
          state_d = DONE;
`ifndef UDP_PKT_SER_HDR_EN
        end else if (wait_q) begin
          wait_d = 1'b0;
`endif
        end else begin
          out_valid_d = 1'b1;
          out_eof_d   = (rem_q == 16'd1);
`ifndef UDP_PKT_SER_HDR_EN
          out_sof_d   = (rem_q == len_q);
`endif
          rem_d  = rem_q - 16'd1;
          lane_d = lane_q + 2'd1;
          // fetch the next word so it lands as lane 0 is due
          tx_req_d = (lane_q == 2'd2) && (rem_q > 16'd2);
          if (lane_q == 2'd0) begin
            out_data_d = tx_data[31:24];
            word_d     = {tx_data[23:0], 8'h00};
          end else begin
            out_data_d = word_q[31:24];
            word_d     = {word_q[23:0], 8'h00};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      rem_q       <= 16'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'd0;
      tx_req_q    <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
`ifdef UDP_PKT_SER_HDR_EN
      hidx_q      <= 3'd0;
`else
      wait_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      tx_req_q    <= tx_req_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
`ifdef UDP_PKT_SER_HDR_EN
      hidx_q      <= hidx_d;
`else
      wait_q      <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_udp_pkt_ser.sv
// Scoreboard bench for udp_pkt_ser; works with or without UDP_PKT_SER_HDR_EN.
module tb_udp_pkt_ser;

`ifdef UDP_PKT_SER_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [15:0] PORT = 16'd1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start_en = 1'b0;
  logic [15:0] tx_byte_num = 16'd0;
  logic        tx_req;
  logic [31:0] tx_data = 32'd0;
  logic        tx_done;
  logic        tx_busy;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;

  udp_pkt_ser dut (
    .eth_tx_clk (clk),
    .rst        (rst),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int s_cyc, sof_cyc, eof_cyc, done_cyc, first_req;
  int req_cnt, done_cnt;
  logic        req_prev = 1'b0;
  logic [31:0] wq[$];
  logic [9:0]  expq[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) req_prev = tx_req;

  // word appears only in the cycle after tx_req; noise otherwise
  always @(posedge clk) begin
    #1;
    if (req_prev)
      tx_data = (wq.size() != 0) ? wq.pop_front() : 32'hBAD0BAD0;
    else
      tx_data = $urandom;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (expq.size() == 0)
          check("extra_byte", 32'(expq.size()), 32'd1);
        else
          check("byte", {22'd0, out_sof, out_eof, out_data},
                {22'd0, expq.pop_front()});
        if (out_sof) sof_cyc = cyc;
        if (out_eof) eof_cyc = cyc;
      end else begin
        check("idle_data", {24'd0, out_data}, 32'd0);
      end
      if (tx_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_pkt(input int n);
    int tot;
    int idx;
    logic [15:0] l;
    logic [15:0] p;
    logic [31:0] w;
    logic [7:0] hb[8];
    l = 16'(n + 8);
    p = PORT;
    hb = '{p[15:8], p[7:0], p[15:8], p[7:0], l[15:8], l[7:0], 8'h00, 8'h00};
    tot = HDR_EN ? n + 8 : n;
    idx = 0;
    if (HDR_EN) begin
      for (int i = 0; i < 8; i++) begin
        expq.push_back({idx == 0, idx == tot - 1, hb[i]});
        idx++;
      end
    end
    for (int i = 0; i < n; i++) begin
      w = wq[i / 4] << (8 * (i % 4));
      expq.push_back({idx == 0, idx == tot - 1, w[31:24]});
      idx++;
    end
    req_cnt = 0; done_cnt = 0; first_req = -1;
    sof_cyc = -1; eof_cyc = -1; done_cyc = -1;
    @(negedge clk);
    tx_start_en = 1'b1;
    tx_byte_num = 16'(n);
    s_cyc = cyc;
    @(negedge clk);
    tx_start_en = 1'b0;
    tx_byte_num = 16'($urandom);
    #1 check("busy_rise", {31'd0, tx_busy}, 32'd1);
  endtask

  task automatic finish_pkt(input int n);
    int tot;
    tot = HDR_EN ? n + 8 : n;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
      #1;
    end
    check("done_seen", {31'd0, done_cnt != 0}, 32'd1);
    check("busy_at_done", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    #1 check("busy_fall", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("done_cnt", done_cnt, 1);
    check("req_cnt", req_cnt, (n + 3) / 4);
    check("exp_left", 32'(expq.size()), 32'd0);
    if (tot > 0) begin
      check("sof_cyc", sof_cyc, s_cyc + (HDR_EN ? 1 : 3));
      check("eof_cyc", eof_cyc, s_cyc + (HDR_EN ? tot : tot + 2));
      check("done_cyc", done_cyc, s_cyc + (HDR_EN ? tot : tot + 2) + 1);
    end else begin
      check("done_cyc", done_cyc, s_cyc + 1);
    end
    if (n > 0) check("first_req", first_req, s_cyc + (HDR_EN ? 7 : 1));
    else check("no_req", first_req, -1);
    wq.delete();
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < (n + 3) / 4; i++) wq.push_back($urandom);
  endtask

  initial begin
    int lens[5] = '{1, 3, 7, 13, 2};
    int target;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_ctl", {27'd0, tx_req, tx_done, tx_busy, out_sof, out_eof}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef UDP_PKT_SER_HDR_EN
    wq.push_back(32'hA1A2A3A4);
    wq.push_back(32'hB1B2B3B4);
    start_pkt(8);
    finish_pkt(8);
    wq.push_back(32'h11223344);
    wq.push_back(32'h55667788);
    start_pkt(5);
    finish_pkt(5);
`else
    wq.push_back(32'hDEADBEEF);
    start_pkt(4);
    finish_pkt(4);
`endif

    start_pkt(0);
    finish_pkt(0);

    foreach (lens[i]) begin
      rand_words(lens[i]);
      start_pkt(lens[i]);
      finish_pkt(lens[i]);
    end

    rand_words(6);
    start_pkt(6);
    repeat (4) @(negedge clk);
    tx_start_en = 1'b1;
    tx_byte_num = 16'd100;
    @(negedge clk);
    tx_start_en = 1'b0;
    finish_pkt(6);

    rand_words(8);
    start_pkt(8);
    target = s_cyc + (HDR_EN ? 8 : 2) + 5;
    for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_ctl", {27'd0, tx_req, tx_done, tx_busy, out_sof, out_eof}, 32'd0);
    rst = 1'b0;
    expq.delete();
    wq.delete();
    req_prev = 1'b0;
    repeat (20) @(negedge clk);
    #1 check("no_done_after_rst", done_cnt, 0);

    wq.push_back(32'hC0FFEE11);
    start_pkt(4);
    finish_pkt(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
